avr_io_shiftout: RTL
====================

# avr_io_shiftout

Serial output stage for the 8-bit I/O path. It takes a byte and clocks it out MSB-first or LSB-first to an external 74HC595-style shift register, then pulses the storage latch. The byte comes either from a CPU write to its DATA register or, optionally, from an upstream parallel port value such as the `port` output of an output-port register. It sits on the same `io_re`/`io_we`/`io_di`/`io_do` bus as the other AVR I/O peripherals and drives board pins directly.

## Interface
- `CLKDIV`, default 4: half-period of `sr_clk` in `clk` cycles. Legal range 1..255.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `io_a`  in  1  register select: 0 = DATA, 1 = CTRL/STATUS.
- `io_re`  in  1  read enable.
- `io_we`  in  1  write enable.
- `io_di`  in  8  write data.
- `io_do`  out  8  read data; 8'h00 when `io_re`=0.
- `par_in`  in  8  upstream parallel byte, used for auto mode.
- `sr_data`  out  1  serial data to the external register.
- `sr_clk`  out  1  shift clock.
- `sr_latch`  out  1  storage latch pulse, active high.
- `irq`  out  1  level interrupt = IE & DONE.

## Operation
- DATA write (`io_a`=0): in IDLE, load the shifter and start a transfer. In any other state the write is ignored and OVR is set. DATA read returns the last byte accepted.
- CTRL write (`io_a`=1):
  - bit1 DONE and bit2 OVR are write-1-to-clear.
  - bit4 AUTO, bit5 LSBF and bit6 IE are read/write.
  - All other bits are ignored.
- STATUS read: bit0 BUSY, bit1 DONE, bit2 OVR, bit4 AUTO, bit5 LSBF, bit6 IE; bits 3 and 7 read 0.
- `io_do` is combinational: register value when `io_re`=1, otherwise 0.
- FSM:
  - IDLE → SHIFT on start.
  - SHIFT: 8 bits, each with `sr_clk` low for CLKDIV cycles, then high for CLKDIV cycles. `sr_data` is stable across the whole bit.
  - SHIFT → LATCH after the 8th high phase. `sr_latch`=1 for CLKDIV cycles.
  - LATCH → IDLE. DONE is set on that transition.
- Bit order: LSBF=0 sends bit7 first; LSBF=1 sends bit0 first. LSBF is sampled at start; changes during a transfer do not affect it.
- Counters:
  - 3-bit bit counter. Terminal value 7 ends SHIFT; it does not wrap into a 9th bit.
  - 8-bit divider counter, counting 0..CLKDIV-1.
- Simultaneous events:
  - DONE set and a DONE w1c in the same cycle: set wins.
  - OVR set and an OVR w1c in the same cycle: set wins.
  - CPU DATA write and an auto trigger in the same cycle: the CPU write wins. The auto request is re-evaluated in the next IDLE cycle.
- Reset during a transfer aborts it with no latch pulse.

## Timing
- Reset values:
  - Outputs: `sr_data`=0, `sr_clk`=0, `sr_latch`=0, `irq`=0, `io_do`=0.
  - Registers: DATA=0, CTRL=0, state IDLE, auto snapshot=0.
- A DATA write sampled at edge N puts the FSM in SHIFT after edge N. BUSY=1 and the first bit is on `sr_data` from then on.
- The first `sr_clk` rising edge occurs CLKDIV cycles after edge N.
- BUSY stays high for exactly 17·CLKDIV cycles.
- DONE and `irq` assert in the cycle BUSY falls.
- A new transfer may start in the first IDLE cycle, so back-to-back transfers have zero gap cycles.
- Outputs are registered with no combinational path from `io_*` to `sr_*`.

## Configuration
- `AVR_IO_SHIFTOUT_AUTO_EN` defined:
  - Auto mode is compiled in.
  - With AUTO=1 and the FSM in IDLE, if `par_in` ≠ the snapshot, start a transfer of `par_in` and update the snapshot at start.
  - Set AUTO with `par_in` equal to the snapshot (0 after reset) and no transfer starts until `par_in` changes.
- Not defined:
  - Snapshot and compare logic are removed.
  - AUTO reads 0 and writes to it are ignored.
  - `par_in` stays on the port but is unused.

## Test plan
- Reset: hold `rst`=0 for 3 cycles → all outputs 0, STATUS reads 8'h00.
- CLKDIV=2, write DATA=8'hA5 with LSBF=0 → `sr_data` sequence 1,0,1,0,0,1,0,1 sampled on 8 `sr_clk` rising edges; `sr_latch` high for 2 cycles; BUSY high for 34 cycles; DONE=1.
- LSBF=1, IE=1, DATA=8'h01 → first bit 1, remaining bits 0; `irq`=1 at the end. Write CTRL 8'h42 (IE kept set, DONE cleared) → `irq`=0.
- DATA write at cycle 5 of a transfer → ignored, STATUS.OVR=1, shifted byte unchanged. CTRL write 8'h04 clears OVR.
- Drop `rst` mid-SHIFT → the next cycle shows IDLE with `sr_clk`/`sr_latch`=0 and no latch pulse afterwards.
- With `AVR_IO_SHIFTOUT_AUTO_EN`:
  - AUTO=1, `par_in` 8'h00→8'h3C → one transfer of 8'h3C.
  - Hold `par_in` steady → no further transfer.
  - Change `par_in` mid-transfer → exactly one follow-up transfer.

Source files
------------

// File: rtl/avr_io_shiftout.sv
// ---------------------------------------------------------------------------
// avr_io_shiftout
//
// Serial output stage for the 8-bit I/O path. A byte is shifted out MSB-first
// or LSB-first to an external 74HC595-style shift register, after which the
// storage latch is pulsed. The byte is taken from a CPU write to the DATA
// register or, in auto mode, from an upstream parallel byte whenever it
// changes.
//
// Optional feature macro: AVR_IO_SHIFTOUT_AUTO_EN
//   defined     -> auto mode (snapshot of par_in + change detect) compiled in
//   not defined -> AUTO reads 0, writes to it are ignored, par_in is unused
//
// Parameters:
//   CLKDIV    half-period of sr_clk in clk cycles (1..255)
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous, active-low reset
//   io_a      register select: 0 = DATA, 1 = CTRL/STATUS
//   io_re     read enable
//   io_we     write enable
//   io_di     write data
//   io_do     read data, 8'h00 when io_re = 0
//   par_in    upstream parallel byte (auto mode)
//   sr_data   serial data to the external register
//   sr_clk    shift clock
//   sr_latch  storage latch pulse, active high
//   irq       level interrupt = IE & DONE
// ---------------------------------------------------------------------------
module avr_io_shiftout #(
   parameter int unsigned CLKDIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       io_a,
   input  logic       io_re,
   input  logic       io_we,
   input  logic [7:0] io_di,
   output logic [7:0] io_do,
   input  logic [7:0] par_in,
   output logic       sr_data,
   output logic       sr_clk,
   output logic       sr_latch,
   output logic       irq
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

   state_t     state_q, state_d;
   logic [7:0] div_q, div_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shreg_q, shreg_d;
   logic [7:0] data_q, data_d;
   logic       order_q, order_d;
   logic       lsbf_q, lsbf_d;
   logic       ie_q, ie_d;
   logic       done_q, done_d;
   logic       ovr_q, ovr_d;
   logic       sr_data_q, sr_data_d;
   logic       sr_clk_q, sr_clk_d;
   logic       sr_latch_q, sr_latch_d;
   logic       auto_rd;

`ifdef AVR_IO_SHIFTOUT_AUTO_EN
   logic       auto_q, auto_d;
   logic [7:0] snap_q, snap_d;

   assign auto_rd = auto_q;
`else
   logic       unused_par_in;

   assign auto_rd       = 1'b0;
   assign unused_par_in = ^par_in;
`endif

   logic       wr_data;
   logic       wr_ctrl;
   logic       start;
   logic [7:0] start_byte;
   logic [7:0] shreg_next;

   assign wr_data = io_we & ~io_a;
   assign wr_ctrl = io_we & io_a;

   // Next-state logic for every register. Control-register clears are applied
   // before any hardware set further down, so a DONE/OVR set in the same cycle
   // as its write-1-to-clear survives. A CPU DATA write in IDLE is checked
   // before the auto trigger, so the CPU wins and the auto request is simply
   // looked at again the next time the FSM sits in IDLE.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      data_d     = data_q;
      order_d    = order_q;
      lsbf_d     = lsbf_q;
      ie_d       = ie_q;
      done_d     = done_q;
      ovr_d      = ovr_q;
      sr_data_d  = sr_data_q;
      sr_clk_d   = sr_clk_q;
      sr_latch_d = sr_latch_q;
      start      = 1'b0;
      start_byte = io_di;
`ifdef AVR_IO_SHIFTOUT_AUTO_EN
      auto_d     = auto_q;
      snap_d     = snap_q;
`endif

      // Walk one bit toward the output end of the shifter in the captured order.
      shreg_next = order_q ? {1'b0, shreg_q[7:1]} : {shreg_q[6:0], 1'b0};

      if (wr_ctrl) begin
         if (io_di[1]) begin
            done_d = 1'b0;
         end
         if (io_di[2]) begin
            ovr_d = 1'b0;
         end
         lsbf_d = io_di[5];
         ie_d   = io_di[6];
`ifdef AVR_IO_SHIFTOUT_AUTO_EN
         auto_d = io_di[4];
`endif
      end

      case (state_q)
         ST_IDLE: begin
            if (wr_data) begin
               start      = 1'b1;
               start_byte = io_di;
`ifdef AVR_IO_SHIFTOUT_AUTO_EN
            end else if (auto_q && (par_in != snap_q)) begin
               start      = 1'b1;
               start_byte = par_in;
               snap_d     = par_in;
`endif
            end
            // Bit order is frozen here so LSBF edits mid-transfer do not matter.
            if (start) begin
               state_d   = ST_SHIFT;
               data_d    = start_byte;
               shreg_d   = start_byte;
               order_d   = lsbf_q;
               sr_data_d = lsbf_q ? start_byte[0] : start_byte[7];
               sr_clk_d  = 1'b0;
               div_d     = 8'd0;
               bit_d     = 3'd0;
            end
         end

         ST_SHIFT: begin
            if (wr_data) begin
               ovr_d = 1'b1;
            end
            if (div_q == DIV_LAST) begin
               div_d = 8'd0;
               if (!sr_clk_q) begin
                  sr_clk_d = 1'b1;
               end else begin
                  sr_clk_d = 1'b0;
                  if (bit_q == 3'd7) begin
                     state_d    = ST_LATCH;
                     sr_latch_d = 1'b1;
                     sr_data_d  = 1'b0;
                  end else begin
                     bit_d     = bit_q + 3'd1;
                     shreg_d   = shreg_next;
                     sr_data_d = order_q ? shreg_next[0] : shreg_next[7];
                  end
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end

         ST_LATCH: begin
            if (wr_data) begin
               ovr_d = 1'b1;
            end
            if (div_q == DIV_LAST) begin
               div_d      = 8'd0;
               state_d    = ST_IDLE;
               sr_latch_d = 1'b0;
               done_d     = 1'b1;
            end else begin
               div_d = div_q + 8'd1;
            end
         end

         default: begin
            state_d    = ST_IDLE;
            sr_clk_d   = 1'b0;
            sr_latch_d = 1'b0;
         end
      endcase
   end

   // State register. Reset is synchronous and active-low; asserting it during
   // a transfer drops straight back to IDLE with the pins low and no latch.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         div_q      <= 8'd0;
         bit_q      <= 3'd0;
         shreg_q    <= 8'd0;
         data_q     <= 8'd0;
         order_q    <= 1'b0;
         lsbf_q     <= 1'b0;
         ie_q       <= 1'b0;
         done_q     <= 1'b0;
         ovr_q      <= 1'b0;
         sr_data_q  <= 1'b0;
         sr_clk_q   <= 1'b0;
         sr_latch_q <= 1'b0;
`ifdef AVR_IO_SHIFTOUT_AUTO_EN
         auto_q     <= 1'b0;
         snap_q     <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
         data_q     <= data_d;
         order_q    <= order_d;
         lsbf_q     <= lsbf_d;
         ie_q       <= ie_d;
         done_q     <= done_d;
         ovr_q      <= ovr_d;
         sr_data_q  <= sr_data_d;
         sr_clk_q   <= sr_clk_d;
         sr_latch_q <= sr_latch_d;
`ifdef AVR_IO_SHIFTOUT_AUTO_EN
         auto_q     <= auto_d;
         snap_q     <= snap_d;
`endif
      end
   end

   // Read mux; the bus expects zero whenever this peripheral is not read.
   always_comb begin
      io_do = 8'h00;
      if (io_re) begin
         if (io_a) begin
            io_do = {1'b0, ie_q, lsbf_q, auto_rd, 1'b0, ovr_q, done_q,
                     (state_q != ST_IDLE)};
         end else begin
            io_do = data_q;
         end
      end
   end

   assign sr_data  = sr_data_q;
   assign sr_clk   = sr_clk_q;
   assign sr_latch = sr_latch_q;
   assign irq      = ie_q & done_q;

endmodule
